// File: rtl/sid_dca_arbiter_pkg.sv
// sid_dca_arbiter_pkg
//   Shared constants for the SID voice DCA arbiter:
//   - default voice count and operand/result widths
//   - a helper that sizes voice-index fields
//   No ports; imported by sid_dca_arbiter and sid_dca_arbiter_rr.
package sid_dca_arbiter_pkg;

   localparam int SID_WAVE_W     = 12;
   localparam int SID_ENV_W      = 8;
   localparam int SID_OUT_W      = 12;
   localparam int SID_NUM_VOICES = 3;

   // Width of a voice index. Never returns 0, so an index field always exists.
   function automatic int sid_idx_w(input int num_voices);
      return (num_voices > 1) ? $clog2(num_voices) : 1;
   endfunction

endpackage

// File: rtl/sid_dca_arbiter_rr.sv
// sid_dca_arbiter_rr
//   Round-robin arbiter that decides which voice gets the shared multiplier.
//   The grant logic is combinational. The last-winner pointer is kept in a
//   register inside this module.
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous, active-high; pointer -> NUM_VOICES-1
//     req    in   [NUM_VOICES]  eligible requesters
//     grant  out  [NUM_VOICES]  one-hot winner (all zero if none)
//     index  out  [IDX_W]       binary index of the winner
//     any    out  1             a winner exists this cycle
module sid_dca_arbiter_rr
   import sid_dca_arbiter_pkg::*;
#(
   parameter int NUM_VOICES = SID_NUM_VOICES,
   localparam int IDX_W     = sid_idx_w(NUM_VOICES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_VOICES-1:0] req,
   output logic [NUM_VOICES-1:0] grant,
   output logic [IDX_W-1:0]      index,
   output logic                  any
);

   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] cand;

   // Scan cyclically, starting one past the last winner. The first hit wins.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_VOICES; k++) begin
         cand = IDX_W'((int'(ptr_reg) + k) % NUM_VOICES);
         if (!any && req[cand]) begin
            any         = 1'b1;
            index       = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   // The reset value NUM_VOICES-1 makes voice 0 the first winner.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_reg <= IDX_W'(NUM_VOICES - 1);
      end else if (any) begin
         ptr_reg <= index;
      end
   end

endmodule

// File: rtl/sid_dca_arbiter.sv
// sid_dca_arbiter
//   Lets NUM_VOICES SID voices share one registered wave x envelope DCA
//   multiplier. Voices are served round-robin through a req/ack handshake.
//   The pipeline has three registered edges:
//     E0  grant: operands and voice id latched, ack pulsed
//     E1  full-width unsigned product
//     E2  result written into the per-voice output bank, valid pulsed
//   Ports:
//     clock      in   system clock
//     reset      in   synchronous, active-high; drops in-flight work
//     req        in   [NUM_VOICES]         held by voice i until ack[i]
//     wave_in    in   [NUM_VOICES*WAVE_W]  voice i at [i*WAVE_W +: WAVE_W]
//     env_in     in   [NUM_VOICES*ENV_W]   voice i at [i*ENV_W +: ENV_W]
//     ack        out  [NUM_VOICES]         1-cycle: operands of voice i captured
//     dca_out    out  [NUM_VOICES*OUT_W]   held per-voice result
//     dca_valid  out  [NUM_VOICES]         1-cycle: dca_out slice i updated
//     busy       out  1                    a pipeline stage holds work
module sid_dca_arbiter
   import sid_dca_arbiter_pkg::*;
#(
   parameter int NUM_VOICES = SID_NUM_VOICES,
   parameter int WAVE_W     = SID_WAVE_W,
   parameter int ENV_W      = SID_ENV_W,
   parameter int OUT_W      = SID_OUT_W
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_VOICES-1:0]        req,
   input  logic [NUM_VOICES*WAVE_W-1:0] wave_in,
   input  logic [NUM_VOICES*ENV_W-1:0]  env_in,
   output logic [NUM_VOICES-1:0]        ack,
   output logic [NUM_VOICES*OUT_W-1:0]  dca_out,
   output logic [NUM_VOICES-1:0]        dca_valid,
   output logic                         busy
);

   localparam int IDX_W  = sid_idx_w(NUM_VOICES);
   localparam int PROD_W = WAVE_W + ENV_W;

   // Handshake / arbitration
   logic [NUM_VOICES-1:0] ack_reg;
   logic [NUM_VOICES-1:0] eligible;
   logic [NUM_VOICES-1:0] grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_any;
   logic [WAVE_W-1:0]     wave_sel;
   logic [ENV_W-1:0]      env_sel;

   // Pipeline stages
   logic                  s1_valid_reg;
   logic [IDX_W-1:0]      s1_id_reg;
   logic [WAVE_W-1:0]     s1_wave_reg;
   logic [ENV_W-1:0]      s1_env_reg;
   logic [PROD_W-1:0]     prod_next;
   logic                  s2_valid_reg;
   logic [IDX_W-1:0]      s2_id_reg;
   logic [PROD_W-1:0]     s2_prod_reg;

   // Per-voice output bank
   logic [OUT_W-1:0]      dca_out_reg   [NUM_VOICES];
   logic                  dca_valid_reg [NUM_VOICES];

   // A voice acked this cycle may still show req (it drops req only after it
   // sees ack). Masking it here keeps one request from being served twice.
   assign eligible = req & ~ack_reg;

   sid_dca_arbiter_rr #(
      .NUM_VOICES (NUM_VOICES)
   ) u_rr (
      .clock (clock),
      .reset (reset),
      .req   (eligible),
      .grant (grant),
      .index (grant_idx),
      .any   (grant_any)
   );

   // Operand mux. Operands are sampled only at the grant edge.
   assign wave_sel  = wave_in[int'(grant_idx)*WAVE_W +: WAVE_W];
   assign env_sel   = env_in[int'(grant_idx)*ENV_W +: ENV_W];

   // Full-width unsigned product. It cannot overflow PROD_W bits.
   assign prod_next = PROD_W'(s1_wave_reg) * PROD_W'(s1_env_reg);

   always_ff @(posedge clock) begin
      if (reset) begin
         ack_reg      <= '0;
         s1_valid_reg <= 1'b0;
         s1_id_reg    <= '0;
         s1_wave_reg  <= '0;
         s1_env_reg   <= '0;
         s2_valid_reg <= 1'b0;
         s2_id_reg    <= '0;
         s2_prod_reg  <= '0;
      end else begin
         ack_reg      <= grant;
         s1_valid_reg <= grant_any;
         if (grant_any) begin
            s1_id_reg   <= grant_idx;
            s1_wave_reg <= wave_sel;
            s1_env_reg  <= env_sel;
         end
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_id_reg   <= s1_id_reg;
            s2_prod_reg <= prod_next;
         end
      end
   end

   // Only one result leaves stage 2 per cycle, so at most one voice updates.
   // The result is the top OUT_W bits of the product.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         always_ff @(posedge clock) begin
            if (reset) begin
               dca_out_reg[gi]   <= '0;
               dca_valid_reg[gi] <= 1'b0;
            end else begin
               dca_valid_reg[gi] <= s2_valid_reg && (s2_id_reg == IDX_W'(gi));
               if (s2_valid_reg && (s2_id_reg == IDX_W'(gi))) begin
                  dca_out_reg[gi] <= s2_prod_reg[PROD_W-1 -: OUT_W];
               end
            end
         end
         assign dca_out[gi*OUT_W +: OUT_W] = dca_out_reg[gi];
         assign dca_valid[gi]              = dca_valid_reg[gi];
      end
   endgenerate

   assign ack  = ack_reg;
   assign busy = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_sid_dca_arbiter.sv
module tb_sid_dca_arbiter;

   localparam int N  = 3;
   localparam int WW = 12;
   localparam int EW = 8;
   localparam int OW = 12;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*WW-1:0] wave_in = '0;
   logic [N*EW-1:0] env_in = '0;
   logic [N-1:0]    ack;
   logic [N*OW-1:0] dca_out;
   logic [N-1:0]    dca_valid;
   logic            busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   sid_dca_arbiter #(
      .NUM_VOICES (N),
      .WAVE_W     (WW),
      .ENV_W      (EW),
      .OUT_W      (OW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .wave_in   (wave_in),
      .env_in    (env_in),
      .ack       (ack),
      .dca_out   (dca_out),
      .dca_valid (dca_valid),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_op(input int v, input int w, input int e);
      wave_in[v*WW +: WW] = WW'(w);
      env_in[v*EW +: EW]  = EW'(e);
   endtask

   // ------------------------------------------------------------------
   // Reference model.
   // The model keeps a list of scheduled results. Each entry holds the
   // cycle the result becomes visible, the voice, and the value
   // (wave*env)>>8. The arbiter state is the last winner, the current ack
   // mask, and a per-voice held result.
   // ------------------------------------------------------------------
   typedef struct {
      int due;
      int v;
      int val;
   } pend_t;

   pend_t        pend[$];
   int           cyc = 0;
   int           m_ptr = N - 1;
   logic [N-1:0] m_ack = '0;
   logic [N-1:0] m_valid = '0;
   logic         m_busy = 1'b0;
   int           m_out[N];
   bit           model_live = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         pend.delete();
         m_ptr   = N - 1;
         m_ack   = '0;
         m_valid = '0;
         m_busy  = 1'b0;
         for (int v = 0; v < N; v++) m_out[v] = 0;
         model_live = 1'b1;
      end else begin
         logic [N-1:0] elig;
         m_valid = '0;
         for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due == cyc) begin
               m_out[pend[i].v]   = pend[i].val;
               m_valid[pend[i].v] = 1'b1;
               pend.delete(i);
            end
         end
         elig  = req & ~m_ack;
         m_ack = '0;
         for (int k = 1; k <= N; k++) begin
            int v;
            v = (m_ptr + k) % N;
            if (m_ack == '0 && elig[v]) begin
               pend_t p;
               m_ack[v] = 1'b1;
               m_ptr    = v;
               p.due    = cyc + 2;
               p.v      = v;
               p.val    = (int'(wave_in[v*WW +: WW]) * int'(env_in[v*EW +: EW])) >> 8;
               pend.push_back(p);
            end
         end
         m_busy = (pend.size() != 0);
      end
      cyc++;
   end

   // Compare every cycle, half a period after the active edge.
   always @(negedge clock) begin
      if (model_live) begin
         check("ack", 32'(ack), 32'(m_ack));
         check("dca_valid", 32'(dca_valid), 32'(m_valid));
         check("busy", 32'(busy), 32'(m_busy));
         for (int v = 0; v < N; v++)
            check($sformatf("dca_out%0d", v), 32'(dca_out[v*OW +: OW]), 32'(m_out[v]));
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with hand-computed literal expectations.
   // ------------------------------------------------------------------
   initial begin
      logic [N-1:0] exp_acks [6];
      exp_acks[0] = 3'b001; exp_acks[1] = 3'b010; exp_acks[2] = 3'b100;
      exp_acks[3] = 3'b001; exp_acks[4] = 3'b010; exp_acks[5] = 3'b100;

      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset ack", 32'(ack), 32'd0);
      check("reset valid", 32'(dca_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset dca_out", 32'(dca_out), 32'd0);
      reset = 1'b0;

      // Single request with max operands.
      set_op(0, 'hFFF, 'hFF);
      req = 3'b001;
      @(negedge clock);
      check("single ack", 32'(ack), 32'b001);
      req = 3'b000;
      @(negedge clock);
      check("single no early valid", 32'(dca_valid), 32'd0);
      @(negedge clock);
      check("single valid", 32'(dca_valid), 32'b001);
      check("single out0", 32'(dca_out[0 +: OW]), 32'hFEF);

      // Scaling: 0x800 * 0x80.
      set_op(1, 'h800, 'h80);
      req = 3'b010;
      @(negedge clock);
      check("scale ack", 32'(ack), 32'b010);
      req = 3'b000;
      repeat (2) @(negedge clock);
      check("scale valid", 32'(dca_valid), 32'b010);
      check("scale out1", 32'(dca_out[OW +: OW]), 32'h400);

      // Zero envelope still produces a valid pulse.
      set_op(0, 'h123, 'h00);
      req = 3'b001;
      @(negedge clock);
      req = 3'b000;
      repeat (2) @(negedge clock);
      check("zero env valid", 32'(dca_valid), 32'b001);
      check("zero env out0", 32'(dca_out[0 +: OW]), 32'h000);

      // Reset asserted in the cycle after ack.
      set_op(1, 'h555, 'h66);
      req = 3'b010;
      @(negedge clock);
      check("midreset ack", 32'(ack), 32'b010);
      req   = 3'b000;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midreset outs cleared", 32'(dca_out), 32'd0);
      repeat (2) begin
         @(negedge clock);
         check("midreset no valid", 32'(dca_valid), 32'd0);
      end

      // Contention: all three voices request continuously.
      set_op(0, 'h100, 'h10);
      set_op(1, 'hABC, 'h40);
      set_op(2, 'h7FF, 'hFF);
      req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check($sformatf("contention ack[%0d]", i), 32'(ack), 32'(exp_acks[i]));
         // Changing operands while req is high is legal.
         if (i == 0) set_op(0, 'h200, 'h10);
      end
      req = 3'b000;
      repeat (3) @(negedge clock);
      check("contention out0", 32'(dca_out[0 +: OW]), 32'h020);
      check("contention out1", 32'(dca_out[OW +: OW]), 32'h2AF);
      check("contention out2", 32'(dca_out[2*OW +: OW]), 32'h7F7);

      // Withdraw: voice 1 drops req before it is granted.
      set_op(0, 'h0F0, 'h22);
      set_op(1, 'h321, 'h99);
      req = 3'b011;
      @(negedge clock);
      check("withdraw ack", 32'(ack), 32'b001);
      req = 3'b000;
      repeat (2) @(negedge clock);
      check("withdraw valid", 32'(dca_valid), 32'b001);
      check("withdraw out0", 32'(dca_out[0 +: OW]), 32'h01F);

      // Hold: idle, outputs stay put.
      repeat (10) begin
         @(negedge clock);
         check("hold valid", 32'(dca_valid), 32'd0);
         check("hold busy", 32'(busy), 32'd0);
         check("hold ack", 32'(ack), 32'd0);
         check("hold out0", 32'(dca_out[0 +: OW]), 32'h01F);
         check("hold out1", 32'(dca_out[OW +: OW]), 32'h2AF);
         check("hold out2", 32'(dca_out[2*OW +: OW]), 32'h7F7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
